// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared types and lane merge helper for the vector register file
package vrf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vrf_state_e;

    // Widest vector the merge helper handles; callers zero-extend and truncate
    localparam int VRF_MAX_W = 1024;

    // Take new bits where the expanded lane mask is set, old bits elsewhere
    function automatic logic [VRF_MAX_W-1:0] lane_merge(
        input logic [VRF_MAX_W-1:0] old_v,
        input logic [VRF_MAX_W-1:0] new_v,
        input logic [VRF_MAX_W-1:0] lane_bits
    );
        return (old_v & ~lane_bits) | (new_v & lane_bits);
    endfunction

endpackage

// File: rtl/vrf_clear_seq.sv
// rtl/vrf_clear_seq.sv - clear sweep sequencer: walks every register index once
module vrf_clear_seq
    import vrf_pkg::*;
#(
    parameter int NUM_VREGS = 8,
    parameter int AW        = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    vrf_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and sweep index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a request in IDLE starts the sweep, the last index ends it
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy    = (state_q == CLEAR);
        clr_en  = (state_q == CLEAR);
        clr_idx = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == AW'(NUM_VREGS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/vector_register_file_mp.sv
// rtl/vector_register_file_mp.sv - multi-port vector register file with bypass, scoreboard and clear
module vector_register_file_mp
    import vrf_pkg::*;
#(
    parameter  int NUM_VREGS = 8,
    parameter  int LANES     = 4,
    parameter  int ELEM_W    = 16,
    parameter  int BYPASS    = 1,
    localparam int VW        = LANES * ELEM_W,
    localparam int AW        = (NUM_VREGS > 2) ? $clog2(NUM_VREGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [VW-1:0]    wd,
    input  logic [LANES-1:0] wmask,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [VW-1:0]    rd0,
    output logic [VW-1:0]    rd1,
    output logic             pend0,
    output logic             pend1,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_a,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
);

    logic [VW-1:0]        regs_q [NUM_VREGS];
    logic [VW-1:0]        regs_d [NUM_VREGS];
    logic [NUM_VREGS-1:0] pend_q, pend_d;
    logic                 wr_drop_q, wr_drop_d;
    logic                 sweep_busy, clr_en;
    logic [AW-1:0]        clr_idx;
    logic [VW-1:0]        wbits;
    logic                 wr_ok, rsv_ok;

    // Addresses past the last register are ignored on writes and read as zero
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_VREGS;
    endfunction

    // Merge the write data into a vector under the current lane mask
    function automatic logic [VW-1:0] merge_wd(input logic [VW-1:0] old_v);
        logic [VRF_MAX_W-1:0] m;
        m = lane_merge(VRF_MAX_W'(old_v), VRF_MAX_W'(wd), VRF_MAX_W'(wbits));
        return m[VW-1:0];
    endfunction

    vrf_clear_seq #(
        .NUM_VREGS (NUM_VREGS),
        .AW        (AW)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (sweep_busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    assign busy    = sweep_busy;
    assign wr_drop = wr_drop_q;
    assign wr_ok   = we  & ~sweep_busy & in_range(wa);
    assign rsv_ok  = rsv & ~sweep_busy & in_range(rsv_a);

    // Expand the per-lane write mask into a per-bit mask
    always_comb begin
        wbits = '0;
        for (int l = 0; l < LANES; l++) begin
            wbits[l*ELEM_W +: ELEM_W] = {ELEM_W{wmask[l]}};
        end
    end

    // Read ports: registered contents, with the in-flight write forwarded when enabled
    always_comb begin
        rd0   = '0;
        rd1   = '0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        if (in_range(ra0)) begin
            rd0   = regs_q[ra0];
            pend0 = pend_q[ra0];
        end
        if (in_range(ra1)) begin
            rd1   = regs_q[ra1];
            pend1 = pend_q[ra1];
        end
        if (BYPASS != 0 && wr_ok && wa == ra0) rd0 = merge_wd(rd0);
        if (BYPASS != 0 && wr_ok && wa == ra1) rd1 = merge_wd(rd1);
    end

    // Next storage/scoreboard state: write clears pending, reserve wins, sweep zeroes
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_VREGS; i++) begin
            if (wr_ok && wa == AW'(i)) begin
                regs_d[i] = merge_wd(regs_q[i]);
                pend_d[i] = 1'b0;
            end
            if (rsv_ok && rsv_a == AW'(i)) pend_d[i] = 1'b1;
            if (clr_en && clr_idx == AW'(i)) begin
                regs_d[i] = '0;
                pend_d[i] = 1'b0;
            end
        end
        wr_drop_d = sweep_busy & (we | rsv);
    end

    // Storage, scoreboard and drop-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VREGS; i++) regs_q[i] <= '0;
            pend_q    <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VREGS; i++) regs_q[i] <= regs_d[i];
            pend_q    <= pend_d;
            wr_drop_q <= wr_drop_d;
        end
    end

endmodule

// File: tb/tb_vector_register_file_mp.sv
// tb/tb_vector_register_file_mp.sv - randomized self-checking bench for vector_register_file_mp
module tb_vector_register_file_mp;

    localparam int N  = 8;
    localparam int L  = 4;
    localparam int EW = 16;
    localparam int VW = 64;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we, rsv, clr_req;
    logic [AW-1:0] wa, ra0, ra1, rsv_a;
    logic [VW-1:0] wd;
    logic [L-1:0]  wmask;
    logic [VW-1:0] rd0, rd1, rd0_nb, rd1_nb;
    logic          pend0, pend1, busy, wr_drop;
    logic          pend0_nb, pend1_nb, busy_nb, wr_drop_nb;

    always #5 clk = ~clk;

    vector_register_file_mp #(.NUM_VREGS(N), .LANES(L), .ELEM_W(EW), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
        .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .pend0(pend0), .pend1(pend1),
        .rsv(rsv), .rsv_a(rsv_a), .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
    );

    vector_register_file_mp #(.NUM_VREGS(N), .LANES(L), .ELEM_W(EW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_nb), .rd1(rd1_nb), .pend0(pend0_nb), .pend1(pend1_nb),
        .rsv(rsv), .rsv_a(rsv_a), .clr_req(clr_req), .busy(busy_nb), .wr_drop(wr_drop_nb)
    );

    // Reference model state
    logic [VW-1:0] m_reg [N];
    logic          m_pend [N];
    int            m_left;
    int            m_pos;
    logic          m_drop;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [VW-1:0] merge(input logic [VW-1:0] o, input logic [VW-1:0] n,
                                            input logic [L-1:0] m);
        logic [VW-1:0] r;
        r = o;
        for (int l = 0; l < L; l++) if (m[l]) r[l*EW +: EW] = n[l*EW +: EW];
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_rd(input logic [AW-1:0] a);
        if (m_left == 0 && we && wa == a) return merge(m_reg[a], wd, wmask);
        return m_reg[a];
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_left = 0;
        m_pos  = 0;
        m_drop = 1'b0;
    endtask

    task automatic idle_inputs();
        we = 1'b0; rsv = 1'b0; clr_req = 1'b0;
        wa = '0; wd = '0; wmask = '0; rsv_a = '0;
    endtask

    // Advance the model across the coming edge using the current inputs, then step the clock
    task automatic tick();
        logic drop_n;
        drop_n = (m_left > 0) && (we || rsv);
        if (m_left > 0) begin
            m_reg[m_pos]  = '0;
            m_pend[m_pos] = 1'b0;
            m_pos++;
            m_left--;
        end else begin
            if (we) begin
                m_reg[wa]  = merge(m_reg[wa], wd, wmask);
                m_pend[wa] = 1'b0;
            end
            if (rsv) m_pend[rsv_a] = 1'b1;
            if (clr_req) begin
                m_left = N;
                m_pos  = 0;
            end
        end
        m_drop = drop_n;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [VW-1:0] d, input logic [L-1:0] m);
        we = 1'b1; wa = AW'(a); wd = d; wmask = m;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ra0 = '0; ra1 = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        n_total++;
        if (busy !== 1'b0 || wr_drop !== 1'b0) $display("FAIL reset_ctrl busy=%b wr_drop=%b want 0/0", busy, wr_drop);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < N; a++) begin
            ra0 = AW'(a); ra1 = AW'(N - 1 - a);
            #1;
            n_total++;
            if (rd0 !== '0 || pend0 !== 1'b0 || rd1 !== '0 || pend1 !== 1'b0)
                $display("FAIL reset_reg%0d rd0=%h pend0=%b rd1=%h pend1=%b want zeros", a, rd0, pend0, rd1, pend1);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_mask();
        write_reg(3, 64'h1111_2222_3333_4444, 4'hF);
        write_reg(3, 64'h5555_5555_5555_5555, 4'b0101);
        ra0 = 3'd3;
        #1;
        n_total++;
        if (rd0 !== 64'h1111_5555_3333_5555) $display("FAIL mask_rd0 got %h want %h", rd0, 64'h1111_5555_3333_5555);
        else n_pass++;
    endtask

    task automatic test_bypass();
        write_reg(2, 64'h0123_4567_89AB_CDEF, 4'hF);
        ra1 = 3'd2;
        we = 1'b1; wa = 3'd2; wd = 64'hAAAA_AAAA_AAAA_AAAA; wmask = 4'hF;
        #1;
        n_total++;
        if (rd1 !== 64'hAAAA_AAAA_AAAA_AAAA) $display("FAIL bypass_on got %h want %h", rd1, 64'hAAAA_AAAA_AAAA_AAAA);
        else n_pass++;
        n_total++;
        if (rd1_nb !== 64'h0123_4567_89AB_CDEF) $display("FAIL bypass_off got %h want %h", rd1_nb, 64'h0123_4567_89AB_CDEF);
        else n_pass++;
        tick();
        wd = 64'hBBBB_BBBB_BBBB_BBBB; wmask = 4'b0011;
        #1;
        n_total++;
        if (rd1 !== 64'hAAAA_AAAA_BBBB_BBBB) $display("FAIL bypass_partial got %h want %h", rd1, 64'hAAAA_AAAA_BBBB_BBBB);
        else n_pass++;
        n_total++;
        if (rd1_nb !== 64'hAAAA_AAAA_AAAA_AAAA) $display("FAIL bypass_off_after got %h want %h", rd1_nb, 64'hAAAA_AAAA_AAAA_AAAA);
        else n_pass++;
        we = 1'b0;
    endtask

    task automatic test_scoreboard();
        ra0 = 3'd5;
        rsv = 1'b1; rsv_a = 3'd5;
        tick();
        rsv = 1'b0;
        n_total++;
        if (pend0 !== 1'b1) $display("FAIL sb_reserve got %b want 1", pend0);
        else n_pass++;
        we = 1'b1; wa = 3'd5; wd = 64'hDEAD_BEEF_0000_1234; wmask = 4'h0;
        #1;
        n_total++;
        if (pend0 !== 1'b1) $display("FAIL sb_no_bypass got %b want 1", pend0);
        else n_pass++;
        tick();
        we = 1'b0;
        n_total++;
        if (pend0 !== 1'b0) $display("FAIL sb_write_clears got %b want 0", pend0);
        else n_pass++;
        we = 1'b1; wa = 3'd5; wd = 64'hCAFE_F00D_1357_9BDF; wmask = 4'hF;
        rsv = 1'b1; rsv_a = 3'd5;
        tick();
        we = 1'b0; rsv = 1'b0;
        n_total++;
        if (pend0 !== 1'b1 || rd0 !== 64'hCAFE_F00D_1357_9BDF)
            $display("FAIL sb_rsv_wins pend=%b rd=%h want 1/%h", pend0, rd0, 64'hCAFE_F00D_1357_9BDF);
        else n_pass++;
    endtask

    task automatic test_clear();
        int  cycles;
        logic saw_drop;
        for (int a = 0; a < N; a++) write_reg(a, rand_vec() | 64'h1, 4'hF);
        rsv = 1'b1; rsv_a = 3'd6; clr_req = 1'b1;
        tick();
        rsv = 1'b0; clr_req = 1'b0;
        cycles = 0;
        saw_drop = 1'b0;
        while (busy === 1'b1 && cycles < 20) begin
            cycles++;
            we = (cycles == 2); wa = 3'd0; wd = rand_vec(); wmask = 4'hF;
            clr_req = (cycles == 4);
            ra0 = AW'($urandom_range(N - 1));
            #1;
            if (wr_drop === 1'b1) saw_drop = 1'b1;
            n_total++;
            if (rd0 !== exp_rd(ra0) || wr_drop !== m_drop)
                $display("FAIL clear_cycle%0d rd0=%h wr_drop=%b want %h/%b", cycles, rd0, wr_drop, exp_rd(ra0), m_drop);
            else n_pass++;
            tick();
        end
        we = 1'b0; clr_req = 1'b0;
        n_total++;
        if (cycles != N) $display("FAIL clear_busy_len got %0d want %0d", cycles, N);
        else n_pass++;
        n_total++;
        if (saw_drop !== 1'b1) $display("FAIL clear_wr_drop got %b want 1", saw_drop);
        else n_pass++;
        for (int a = 0; a < N; a++) begin
            ra0 = AW'(a);
            #1;
            n_total++;
            if (rd0 !== '0 || pend0 !== 1'b0) $display("FAIL clear_reg%0d rd=%h pend=%b want 0/0", a, rd0, pend0);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int guard;
        for (int a = 0; a < N; a++) write_reg(a, rand_vec() | 64'h1, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy);
        else n_pass++;
        for (int a = 0; a < N; a++) begin
            ra0 = AW'(a);
            #1;
            n_total++;
            if (rd0 !== '0) $display("FAIL midrst_reg%0d got %h want 0", a, rd0);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        write_reg(0, 64'h0000_0000_0000_00F0, 4'hF);
        write_reg(1, 64'h0000_0000_0000_0F00, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL restart_busy got %b want 1", busy);
        else n_pass++;
        tick();
        ra0 = 3'd0; ra1 = 3'd1;
        #1;
        n_total++;
        if (rd0 !== '0 || rd1 !== 64'h0000_0000_0000_0F00)
            $display("FAIL restart_idx0 rd0=%h rd1=%h want 0/%h", rd0, rd1, 64'h0000_0000_0000_0F00);
        else n_pass++;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            guard++;
            tick();
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL restart_done busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we      = $urandom_range(1);
            wa      = AW'($urandom_range(N - 1));
            wd      = rand_vec();
            wmask   = L'($urandom_range(15));
            rsv     = ($urandom_range(3) == 0);
            rsv_a   = AW'($urandom_range(N - 1));
            clr_req = ($urandom_range(39) == 0);
            ra0     = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(N - 1));
            ra1     = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(N - 1));
            #1;
            n_total++;
            if (rd0 !== exp_rd(ra0) || rd1 !== exp_rd(ra1) || pend0 !== m_pend[ra0] || pend1 !== m_pend[ra1]
                || busy !== (m_left > 0) || wr_drop !== m_drop)
                $display("FAIL rand_c%0d rd0=%h rd1=%h p=%b%b busy=%b drop=%b want %h %h %b%b %b %b",
                         c, rd0, rd1, pend0, pend1, busy, wr_drop, exp_rd(ra0), exp_rd(ra1),
                         m_pend[ra0], m_pend[ra1], (m_left > 0), m_drop);
            else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_mask();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
